execute_iter: RTL and testbench

- Parametrised next-generation execute stage.
- Operand forwarding muxes, single-cycle ALU ops, and an iterative multi-cycle multiplier.
- Valid/ready input handshake, downstream stall hold, flush, and a registered EX/MEM output.
- Sits between decode and memory stages; carries an instruction tag alongside the result.

---
 rtl/exec_pkg.sv | 31 +++
 rtl/exec_iter_engine.sv | 88 ++++++++
 rtl/execute_iter.sv | 170 +++++++++++++++++
 tb/tb_execute_iter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: op codes, forward selects, FSM states, engine modes.
// Optional divider is enabled with the EXEC_ITER_DIV_EN macro.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_XOR   = 3'b011,
        OP_ANDN  = 3'b100,
        OP_PASSB = 3'b101,
        OP_MUL   = 3'b110,
        OP_DIV   = 3'b111
    } op_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_EX  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_e;

    typedef enum logic {
        ENG_MUL,
        ENG_DIV
    } eng_mode_e;

endpackage

// File: rtl/exec_iter_engine.sv
// Iterative shift-add multiplier, one bit per cycle; with EXEC_ITER_DIV_EN it also
// performs an unsigned restoring divide on the same hi/lo registers and counter.
module exec_iter_engine
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  eng_mode_e        mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   mul_sum;

    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

`ifdef EXEC_ITER_DIV_EN
    logic           div_q;
    logic           b_zero;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] rem_try;

    assign b_zero  = (opnd == '0);
    assign rem_sh  = {hi, lo[WIDTH-1]};
    assign rem_try = rem_sh - {1'b0, opnd};
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // done flags the final iteration so the owner FSM reaches DONE as the counter hits 0
    assign done = (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
`ifdef EXEC_ITER_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start) begin
            cnt  <= CNT_W'(WIDTH);
            hi   <= '0;
            lo   <= a;
            opnd <= b;
`ifdef EXEC_ITER_DIV_EN
            div_q <= (mode == ENG_DIV);
`endif
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
`ifdef EXEC_ITER_DIV_EN
            if (div_q) begin
                hi <= rem_try[WIDTH] ? rem_sh[WIDTH-1:0] : rem_try[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], ~rem_try[WIDTH]};
            end else
`endif
            begin
                {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        result = lo;
        ovf    = |hi;
`ifdef EXEC_ITER_DIV_EN
        if (div_q) begin
            result = b_zero ? '1 : lo;
            ovf    = b_zero;
        end
`endif
    end

endmodule

// File: rtl/execute_iter.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL (and DIV when
// EXEC_ITER_DIV_EN is defined), stall/flush handling and a registered EX/MEM output.
module execute_iter
    import exec_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               TAG_W     = 16,
    parameter logic [TAG_W-1:0] RESET_TAG = TAG_W'(16'h0800)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             busy
);

    state_e           state;
    op_e              op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             is_iter;
    logic             accept;
    logic             eng_start;
    eng_mode_e        eng_mode;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;
    logic             eng_ovf;
    logic [TAG_W-1:0] tag_q;

    assign in_ready  = (state == IDLE) & ~stall;
    assign accept    = in_valid & in_ready;
    assign eng_start = accept & ~flush & is_iter;

    always_comb begin
        op = op_e'(in_op);
        case (fwd_a)
            FWD_REG: op_a = in_a;
            FWD_WB:  op_a = wb_data;
            FWD_EX:  op_a = out_result;
            default: op_a = in_a;
        endcase
        case (fwd_b)
            FWD_REG: op_b = in_b;
            FWD_WB:  op_b = wb_data;
            FWD_EX:  op_b = out_result;
            default: op_b = in_b;
        endcase
`ifdef EXEC_ITER_DIV_EN
        is_iter = (op == OP_MUL) || (op == OP_DIV);
`else
        is_iter = (op == OP_MUL);
`endif
        eng_mode = (op == OP_DIV) ? ENG_DIV : ENG_MUL;
    end

    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:   alu_res = op_a & op_b;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_ANDN:  alu_res = op_a & ~op_b;
            OP_PASSB: alu_res = op_b;
`ifndef EXEC_ITER_DIV_EN
            OP_DIV:   alu_ovf = 1'b1;
`endif
            default: ;
        endcase
    end

    exec_iter_engine #(
        .WIDTH(WIDTH)
    ) u_engine (
        .clk    (clk),
        .rst    (rst),
        .start  (eng_start),
        .mode   (eng_mode),
        .a      (op_a),
        .b      (op_b),
        .done   (eng_done),
        .result (eng_result),
        .ovf    (eng_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            tag_q      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_tag    <= RESET_TAG;
        end else begin
            // unstalled cycles without a new result become bubbles
            if (!stall) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept && !flush) begin
                        if (is_iter) begin
                            state <= MUL;
                            busy  <= 1'b1;
                            tag_q <= in_tag;
                        end else begin
                            out_valid  <= 1'b1;
                            out_result <= alu_res;
                            out_ovf    <= alu_ovf;
                            out_tag    <= in_tag;
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (eng_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!stall) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                        out_result <= eng_result;
                        out_ovf    <= eng_ovf;
                        out_tag    <= tag_q;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_iter.sv
// Scoreboard bench for execute_iter: directed scenarios then randomized traffic against
// a cycle-level reference model; a separate monitor checks every output edge.
module tb_execute_iter;

    localparam int W = 16;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic [15:0] tag;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_tag;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] wb_data;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_result;
    logic [15:0] out_tag;
    logic        out_ovf;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t        sb[$];
    bit          m_idle = 1'b1;
    int          m_rem = 0;
    exp_t        m_pend;
    logic [15:0] m_out = '0;

    logic        last_stall = 1'b0;
    logic        last_rst = 1'b1;
    logic        p_valid;
    logic [15:0] p_res;
    logic [15:0] p_tag;
    logic        p_ovf;

    execute_iter #(
        .WIDTH(16),
        .TAG_W(16),
        .RESET_TAG(16'h0800)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .wb_data    (wb_data),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_multi(input logic [2:0] op);
`ifdef EXEC_ITER_DIV_EN
        return (op == 3'd6) || (op == 3'd7);
`else
        return (op == 3'd6);
`endif
    endfunction

    task automatic ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic o);
        int unsigned       ua;
        int unsigned       ub;
        int                sa;
        int                sbv;
        longint unsigned   p;
        ua  = a;
        ub  = b;
        sa  = $signed(a);
        sbv = $signed(b);
        r   = '0;
        o   = 1'b0;
        case (op)
            3'd0: begin
                r = 16'(ua + ub);
                o = (sa + sbv > 32767) || (sa + sbv < -32768);
            end
            3'd1: begin
                r = 16'(ua - ub);
                o = (sa - sbv > 32767) || (sa - sbv < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = a ^ b;
            3'd4: r = a & ~b;
            3'd5: r = b;
            3'd6: begin
                p = longint'(ua) * longint'(ub);
                r = 16'(p);
                o = (p > 64'd65535);
            end
            default: begin
`ifdef EXEC_ITER_DIV_EN
                if (ub == 0) begin
                    r = 16'hFFFF;
                    o = 1'b1;
                end else begin
                    r = 16'(ua / ub);
                end
`else
                o = 1'b1;
`endif
            end
        endcase
    endtask

    // Model of one clock edge given the inputs presented during the preceding cycle
    task automatic model_edge(input logic v, input logic [2:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] tag,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [15:0] wb, input logic st, input logic fl);
        logic [15:0] oa;
        logic [15:0] ob;
        logic [15:0] r;
        logic        o;
        exp_t        e;
        if (m_idle) begin
            if (v && !st && !fl) begin
                oa = (fa == 2'b01) ? wb : (fa == 2'b10) ? m_out : a;
                ob = (fb == 2'b01) ? wb : (fb == 2'b10) ? m_out : b;
                ref_op(op, oa, ob, r, o);
                e.res = r;
                e.ovf = o;
                e.tag = tag;
                e.cyc = cyc;
                if (is_multi(op)) begin
                    m_idle = 1'b0;
                    m_rem  = W;
                    m_pend = e;
                end else begin
                    sb.push_back(e);
                    m_out = r;
                end
            end
        end else if (fl) begin
            m_idle = 1'b1;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (!st) begin
            m_pend.cyc = cyc;
            sb.push_back(m_pend);
            m_out  = m_pend.res;
            m_idle = 1'b1;
        end
    endtask

    task automatic cycle(input logic v, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] tag,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [15:0] wb, input logic st, input logic fl);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        fwd_a    = fa;
        fwd_b    = fb;
        wb_data  = wb;
        stall    = st;
        flush    = fl;
        #1;
        chk("in_ready", in_ready, m_idle && !st);
        chk("busy", busy, !m_idle);
        @(posedge clk);
        cyc++;
        model_edge(v, op, a, b, tag, fa, fb, wb, st, fl);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            cycle(1'b0, 3'd0, '0, '0, '0, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] tag, output int n);
        cycle(1'b1, op, a, b, tag, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            idle(1);
            n++;
        end
        chk("op_timeout", n < 40, 1'b1);
    endtask

    always @(posedge clk) begin
        last_stall <= stall;
        last_rst   <= rst;
    end

    // Monitor: every output edge is either a held value, the next scoreboard entry, or a bubble
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !last_rst) begin
                if (last_stall) begin
                    chk("hold_valid", out_valid, p_valid);
                    chk("hold_result", out_result, p_res);
                    chk("hold_tag", out_tag, p_tag);
                    chk("hold_ovf", out_ovf, p_ovf);
                end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    chk("sb_valid", out_valid, 1'b1);
                    chk("sb_result", out_result, e.res);
                    chk("sb_ovf", out_ovf, e.ovf);
                    chk("sb_tag", out_tag, e.tag);
                end else begin
                    chk("bubble", out_valid, 1'b0);
                end
            end
            p_valid = out_valid;
            p_res   = out_result;
            p_tag   = out_tag;
            p_ovf   = out_ovf;
        end
    end

    initial begin
        int n;
        logic [2:0]  rop;
        logic [15:0] rb;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = '0;
        in_a     = '0;
        in_b     = '0;
        in_tag   = '0;
        fwd_a    = '0;
        fwd_b    = '0;
        wb_data  = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_result", out_result, 16'h0000);
        chk("rst_tag", out_tag, 16'h0800);
        chk("rst_ovf", out_ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // asynchronous reset in the middle of a multiply
        cycle(1'b1, 3'd6, 16'h0003, 16'h0005, 16'h0001, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        idle(4);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_tag", out_tag, 16'h0800);
        m_idle = 1'b1;
        m_out  = '0;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b1, 3'd0, 16'h0002, 16'h0003, 16'h0042, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        chk("post_rst_res", out_result, 16'h0005);
        chk("post_rst_valid", out_valid, 1'b1);

        // back-to-back ADD / SUB with overflow boundary
        cycle(1'b1, 3'd0, 16'h7FFF, 16'h0001, 16'h0010, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        chk("add_res", out_result, 16'h8000);
        chk("add_ovf", out_ovf, 1'b1);
        cycle(1'b1, 3'd1, 16'h0005, 16'h0007, 16'h0011, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        chk("sub_res", out_result, 16'hFFFE);
        chk("sub_ovf", out_ovf, 1'b0);
        chk("sub_tag", out_tag, 16'h0011);

        // forwarding from own output and from writeback
        cycle(1'b1, 3'd0, 16'h000F, 16'h0001, 16'h0012, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 16'hDEAD, 16'h0001, 16'h0013, 2'b10, 2'b00, '0, 1'b0, 1'b0);
        chk("fwd_ex", out_result, 16'h0011);
        cycle(1'b1, 3'd5, 16'h0000, 16'h1234, 16'h0014, 2'b00, 2'b01, 16'h0100, 1'b0, 1'b0);
        chk("fwd_wb", out_result, 16'h0100);

        // multiply latency and overflow
        run_op(3'd6, 16'h0123, 16'h0010, 16'h0020, n);
        chk("mul_latency", n, 17);
        chk("mul_res", out_result, 16'h1230);
        chk("mul_ovf", out_ovf, 1'b0);
        run_op(3'd6, 16'h8000, 16'h0002, 16'h0021, n);
        chk("mul_ovf_res", out_result, 16'h0000);
        chk("mul_ovf_flag", out_ovf, 1'b1);

        // stall while the multiply sits in DONE
        cycle(1'b1, 3'd0, 16'h0070, 16'h0007, 16'h0030, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 16'h0003, 16'h0004, 16'h0031, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        idle(W);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'd0, 16'h1111, 16'h2222, 16'h0032, 2'b00, 2'b00, '0, 1'b1, 1'b0);
            chk("stall_res", out_result, 16'h0077);
            chk("stall_valid", out_valid, 1'b0);
        end
        idle(1);
        chk("stall_mul_res", out_result, 16'h000C);
        chk("stall_mul_tag", out_tag, 16'h0031);

        // flush during multiply
        cycle(1'b1, 3'd6, 16'h0101, 16'h0002, 16'h0BAD, 2'b00, 2'b00, '0, 1'b0, 1'b0);
        idle(3);
        cycle(1'b0, 3'd0, '0, '0, '0, 2'b00, 2'b00, '0, 1'b0, 1'b1);
        chk("flush_busy", busy, 1'b0);
        idle(20);
        chk("flush_no_tag", out_tag == 16'h0BAD, 1'b0);

`ifdef EXEC_ITER_DIV_EN
        run_op(3'd7, 16'd100, 16'd7, 16'h0040, n);
        chk("div_latency", n, 17);
        chk("div_res", out_result, 16'd14);
        chk("div_ovf", out_ovf, 1'b0);
        run_op(3'd7, 16'd100, 16'd0, 16'h0041, n);
        chk("div0_res", out_result, 16'hFFFF);
        chk("div0_ovf", out_ovf, 1'b1);
`else
        run_op(3'd7, 16'd100, 16'd7, 16'h0040, n);
        chk("div_latency", n, 0);
        chk("div_res", out_result, 16'h0000);
        chk("div_ovf", out_ovf, 1'b1);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rop = 3'($urandom_range(0, 7));
            rb  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rb = rb & 16'h000F;
            cycle(1'($urandom_range(0, 3) != 0), rop, 16'($urandom), rb, 16'($urandom),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 19) == 0));
        end
        idle(25);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
